// File: rtl/simon_pkg.sv
// Shared types for the Simon playback path: sequencer states and colour codes.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        ON,
        GAP,
        DONE
    } play_state_t;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        RED    = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_t;

    // One-hot LED pattern for a colour (bit n lights colour n).
    function automatic logic [3:0] color_onehot(input color_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/simon_play_sequencer_if.sv
// Playback bus between the game FSM / sequence RAM side (master) and the sequencer (slave).
interface simon_play_sequencer_if #(
    parameter int unsigned LW = 5
);
    import simon_pkg::*;

    logic          start;
    logic          abort;
    logic [LW-1:0] seq_len;
    logic          step_rd;
    logic [LW-1:0] step_addr;
    logic [1:0]    step_data;
    logic [3:0]    led;
    logic          tone_en;
    color_t        tone_sel;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, seq_len, step_data,
        input  step_rd, step_addr, led, tone_en, tone_sel, busy, done
    );

    modport slave (
        input  start, abort, seq_len, step_data,
        output step_rd, step_addr, led, tone_en, tone_sel, busy, done
    );

endinterface

// File: rtl/simon_tick_div.sv
// Timing prescaler: one-cycle tick every TICK_DIV cycles; clr restarts the phase.
module simon_tick_div #(
    parameter int unsigned TICK_DIV = 12000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    // tick_q mirrors (cnt_q == LAST), computed one cycle ahead so it stays registered.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= (TICK_DIV == 1);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/simon_play_sequencer.sv
// Simon sequence playback: fetches each colour from RAM and drives LED/tone with fixed on/gap timing.
// Optional SIMON_SPEEDUP_EN halves the on/gap durations for long sequences.
module simon_play_sequencer
    import simon_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 12000,
    parameter int unsigned ON_TICKS    = 300,
    parameter int unsigned GAP_TICKS   = 100,
    parameter int unsigned MAX_LEN     = 31,
    parameter int unsigned SPEEDUP_LEN = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    simon_play_sequencer_if.slave bus
);
    localparam int unsigned LW       = $clog2(MAX_LEN + 1);
    localparam int unsigned MAX_T    = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int unsigned TW       = $clog2(MAX_T + 1);
    localparam int unsigned ON_FAST  = ((ON_TICKS >> 1) > 0) ? (ON_TICKS >> 1) : 1;
    localparam int unsigned GAP_FAST = ((GAP_TICKS >> 1) > 0) ? (GAP_TICKS >> 1) : 1;
`ifdef SIMON_SPEEDUP_EN
    localparam bit SPEEDUP_ON = 1'b1;
`else
    localparam bit SPEEDUP_ON = 1'b0;
`endif

    play_state_t   state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    color_t        color_q, color_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          fast_q, fast_d;

    logic          step_rd_q, step_rd_d;
    logic [LW-1:0] step_addr_q, step_addr_d;
    logic [3:0]    led_q, led_d;
    logic          tone_en_q, tone_en_d;
    color_t        tone_sel_q, tone_sel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          tick;
    logic          abort_c;
    logic [LW-1:0] len_req;
    logic [TW-1:0] on_load, gap_load;

    simon_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == WAIT_DATA),
        .tick  (tick)
    );

    assign abort_c  = bus.abort && (state_q != IDLE);
    assign len_req  = (32'(bus.seq_len) > MAX_LEN) ? LW'(MAX_LEN) : bus.seq_len;
    assign on_load  = fast_q ? TW'(ON_FAST)  : TW'(ON_TICKS);
    assign gap_load = fast_q ? TW'(GAP_FAST) : TW'(GAP_TICKS);

    // Next-state and registered-output decode; outputs follow the state being entered.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        color_d = color_q;
        tcnt_d  = tcnt_q;
        fast_d  = fast_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    len_d   = len_req;
                    idx_d   = '0;
                    fast_d  = SPEEDUP_ON && (32'(len_req) >= SPEEDUP_LEN);
                    state_d = (len_req == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_d = WAIT_DATA;
            WAIT_DATA: begin
                color_d = color_t'(bus.step_data);
                tcnt_d  = on_load;
                state_d = ON;
            end
            ON: begin
                if (tick) begin
                    if (tcnt_q == TW'(1)) begin
                        tcnt_d  = gap_load;
                        state_d = GAP;
                    end else begin
                        tcnt_d = tcnt_q - TW'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (tcnt_q != TW'(1)) begin
                        tcnt_d = tcnt_q - TW'(1);
                    end else if (idx_q == len_q - LW'(1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + LW'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_c) begin
            state_d = IDLE;
            idx_d   = '0;
        end

        step_rd_d   = (state_d == FETCH);
        step_addr_d = idx_d;
        led_d       = (state_d == ON) ? color_onehot(color_d) : 4'b0000;
        tone_en_d   = (state_d == ON);
        tone_sel_d  = (state_d == ON) ? color_d : tone_sel_q;
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        if (abort_c) begin
            tone_sel_d = GREEN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            color_q     <= GREEN;
            tcnt_q      <= '0;
            fast_q      <= 1'b0;
            step_rd_q   <= 1'b0;
            step_addr_q <= '0;
            led_q       <= 4'b0000;
            tone_en_q   <= 1'b0;
            tone_sel_q  <= GREEN;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            color_q     <= color_d;
            tcnt_q      <= tcnt_d;
            fast_q      <= fast_d;
            step_rd_q   <= step_rd_d;
            step_addr_q <= step_addr_d;
            led_q       <= led_d;
            tone_en_q   <= tone_en_d;
            tone_sel_q  <= tone_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.step_rd   = step_rd_q;
    assign bus.step_addr = step_addr_q;
    assign bus.led       = led_q;
    assign bus.tone_en   = tone_en_q;
    assign bus.tone_sel  = tone_sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_simon_play_sequencer.sv
// Randomized bench for simon_play_sequencer against a cycle-arithmetic playback model.
module tb_simon_play_sequencer;
    import simon_pkg::*;

    localparam int unsigned TICK_DIV    = 4;
    localparam int unsigned ON_TICKS    = 3;
    localparam int unsigned GAP_TICKS   = 2;
    localparam int unsigned MAX_LEN     = 31;
    localparam int unsigned SPEEDUP_LEN = 2;
    localparam int unsigned LW          = $clog2(MAX_LEN + 1);
`ifdef SIMON_SPEEDUP_EN
    localparam bit SPD = 1'b1;
`else
    localparam bit SPD = 1'b0;
`endif

    typedef struct packed {
        int rd;
        int addr;
        int led;
        int ten;
        int tsel;
        int busy;
        int done;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   ram [MAX_LEN];
    int   tone_prev;

    simon_play_sequencer_if #(.LW(LW)) bus ();

    simon_play_sequencer #(
        .TICK_DIV    (TICK_DIV),
        .ON_TICKS    (ON_TICKS),
        .GAP_TICKS   (GAP_TICKS),
        .MAX_LEN     (MAX_LEN),
        .SPEEDUP_LEN (SPEEDUP_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int on_cycles(input int len);
        int t = ON_TICKS;
        if (SPD && len >= int'(SPEEDUP_LEN)) t = (ON_TICKS / 2 > 0) ? ON_TICKS / 2 : 1;
        return t * TICK_DIV;
    endfunction

    function automatic int gap_cycles(input int len);
        int t = GAP_TICKS;
        if (SPD && len >= int'(SPEEDUP_LEN)) t = (GAP_TICKS / 2 > 0) ? GAP_TICKS / 2 : 1;
        return t * TICK_DIV;
    endfunction

    // Expected outputs in cycle k after a start accepted at cycle 0.
    function automatic exp_t model(input int k, input int len, input int abort_at);
        exp_t e;
        int p, done_cyc, s, off, shown;
        e = '0;
        p = 2 + on_cycles(len) + gap_cycles(len);
        done_cyc = 1 + len * p;
        if (abort_at > 0 && k > abort_at) return e;
        if (k < done_cyc) begin
            s     = (k - 1) / p;
            off   = (k - 1) % p;
            e.rd  = (off == 0);
            e.addr = s;
            e.busy = 1;
            if (off >= 2 && off < 2 + on_cycles(len)) begin
                e.led = 1 << ram[s];
                e.ten = 1;
            end
            shown  = (off >= 2) ? s + 1 : s;
            e.tsel = (shown == 0) ? tone_prev : ram[shown - 1];
        end else begin
            e.tsel = (len == 0) ? tone_prev : ram[len - 1];
            if (k == done_cyc) begin
                e.busy = 1;
                e.done = 1;
            end
        end
        return e;
    endfunction

    task automatic fill_ram();
        for (int i = 0; i < int'(MAX_LEN); i++) ram[i] = int'($urandom_range(0, 3));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " led"},     32'(bus.led),      0);
        check({tag, " tone_en"}, 32'(bus.tone_en),  0);
        check({tag, " tone_sel"},32'(bus.tone_sel), 0);
        check({tag, " step_rd"}, 32'(bus.step_rd),  0);
        check({tag, " addr"},    32'(bus.step_addr),0);
        check({tag, " busy"},    32'(bus.busy),     0);
        check({tag, " done"},    32'(bus.done),     0);
    endtask

    // Plays one sequence; stop_at > 0 leaves early at the negedge of that cycle.
    task automatic run_play(input int len, input int abort_at, input int xstart_at, input int stop_at);
        int   p, done_cyc, last, addr_prev;
        bit   rd_prev;
        exp_t e;
        string t;
        p         = 2 + on_cycles(len) + gap_cycles(len);
        done_cyc  = 1 + len * p;
        last      = (abort_at > 0) ? abort_at + 2 : done_cyc + 2;
        if (stop_at > 0) last = stop_at;
        rd_prev   = 1'b0;
        addr_prev = 0;
        @(negedge clk);
        check("c0 busy", 32'(bus.busy), 0);
        bus.start   = 1'b1;
        bus.abort   = 1'b0;
        bus.seq_len = LW'(len);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            bus.start   = (k == xstart_at);
            bus.abort   = (k == abort_at);
            bus.seq_len = LW'($urandom_range(0, MAX_LEN));
            bus.step_data = rd_prev ? 2'(ram[addr_prev])
                                    : 2'(ram[addr_prev] + 1 + int'($urandom_range(0, 2)));
            e = model(k, len, abort_at);
            t = $sformatf("len%0d c%0d", len, k);
            check({t, " step_rd"}, 32'(bus.step_rd), 32'(e.rd));
            if (e.rd != 0) check({t, " addr"}, 32'(bus.step_addr), 32'(e.addr));
            check({t, " led"},      32'(bus.led),      32'(e.led));
            check({t, " tone_en"},  32'(bus.tone_en),  32'(e.ten));
            check({t, " tone_sel"}, 32'(bus.tone_sel), 32'(e.tsel));
            check({t, " busy"},     32'(bus.busy),     32'(e.busy));
            check({t, " done"},     32'(bus.done),     32'(e.done));
            rd_prev   = bus.step_rd;
            addr_prev = int'(bus.step_addr);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (stop_at <= 0) begin
            if (abort_at > 0) tone_prev = 0;
            else if (len > 0) tone_prev = ram[len - 1];
        end
    endtask

    initial begin
        int len, ab, xs, p;
        n_checks      = 0;
        n_fail        = 0;
        tone_prev     = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.seq_len   = '0;
        bus.step_data = 2'd0;
        fill_ram();
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        ram[0] = 2;
        ram[1] = 0;
        run_play(2, 0, 0, 0);
        run_play(0, 0, 0, 0);
        fill_ram();
        run_play(3, 10, 0, 0);
        ram[0] = 2;
        ram[1] = 0;
        run_play(2, 0, 5, 0);
        run_play(1, 0, 0, 0);

        // start together with abort while idle must be ignored
        @(negedge clk);
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        bus.seq_len = LW'(3);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("start+abort c%0d busy", i + 1), 32'(bus.busy), 0);
            check($sformatf("start+abort c%0d step_rd", i + 1), 32'(bus.step_rd), 0);
            @(negedge clk);
        end

        // asynchronous reset in the middle of the first ON phase
        fill_ram();
        run_play(2, 0, 0, 7);
        @(posedge clk);
        #1;
        check("pre-reset led", 32'(bus.led), 32'(1 << ram[0]));
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tone_prev = 0;
        fill_ram();
        run_play(2, 0, 0, 0);

        fill_ram();
        run_play(int'(MAX_LEN), 0, 0, 0);

        for (int r = 0; r < 14; r++) begin
            fill_ram();
            len = int'($urandom_range(0, 4));
            p   = 1 + len * (2 + on_cycles(len) + gap_cycles(len));
            ab  = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, p)) : 0;
            xs  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (ab > 0) ? ab : p)) : 0;
            run_play(len, ab, xs, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_play_sequencer.md
# simon_play_sequencer

Plays back the stored colour sequence of the Simon game on the four LEDs and the speaker-tone selector, one step at a time, with fixed on/gap timing. It sits between the game FSM (which issues `start` and `seq_len`) and the sequence RAM, tone generator and LED outputs. It is the only master of the LED/tone resource during playback. While `busy` is low, the game FSM owns the LEDs and tone for button echo.

## Interface
Parameters:
- `TICK_DIV`, 12000: clock cycles per timing tick (1 ms at 12 MHz).
- `ON_TICKS`, 300: ticks each step's LED and tone are active.
- `GAP_TICKS`, 100: ticks of silence/dark after each step.
- `MAX_LEN`, 31: maximum sequence length; `LW = $clog2(MAX_LEN+1)`.
- `SPEEDUP_LEN`, 14: length at which playback accelerates (used only with `SIMON_SPEEDUP_EN`).

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle request to play steps 0..seq_len-1.
- `abort`, in, 1: stop playback immediately.
- `seq_len`, in, LW: number of steps to play; sampled on accepted `start`.
- `step_rd`, out, 1: sequence RAM read strobe.
- `step_addr`, out, LW: RAM address, equal to the current step index.
- `step_data`, in, 2: colour code, valid the cycle after `step_rd`.
- `led`, out, 4: one-hot LED drive (bit n = colour n).
- `tone_en`, out, 1: speaker tone enable.
- `tone_sel`, out, 2: tone index, equal to the colour code.
- `busy`, out, 1: playback in progress.
- `done`, out, 1: one-cycle pulse on normal completion.

## Operation
- States: IDLE, FETCH, WAIT_DATA, ON, GAP, DONE.
- IDLE: `start`=1 and `abort`=0 latches `len = min(seq_len, MAX_LEN)` and sets index to 0.
  - If `len` is 0, go to DONE.
  - Otherwise go to FETCH.
- FETCH, one cycle: `step_rd`=1, `step_addr`=index, then WAIT_DATA.
- WAIT_DATA, one cycle: capture `step_data` into the colour register, load the tick counter, then ON.
- ON: `led`=1<<colour, `tone_en`=1, `tone_sel`=colour. Lasts `ON_TICKS*TICK_DIV` cycles, then GAP.
- GAP: `led`=0, `tone_en`=0. Lasts `GAP_TICKS*TICK_DIV` cycles.
  - If index equals len-1, go to DONE.
  - Otherwise increment index and go to FETCH.
- DONE, one cycle: `done`=1, then IDLE.
- `busy`=1 in every state except IDLE.
- `start` while busy is ignored; `seq_len` changes while busy are ignored.
- `abort`=1 in any non-IDLE state: IDLE next cycle, all outputs 0, no `done` pulse.
- `abort` and `start` in the same IDLE cycle: `start` is ignored.
- `tone_sel` holds the last colour outside ON. Consumers must gate it with `tone_en`.
- The index never wraps: the maximum value is MAX_LEN-1.

## Timing
- Reset (async assert): state IDLE; `led`=0, `tone_en`=0, `tone_sel`=0, `step_rd`=0, `step_addr`=0, `busy`=0, `done`=0.
- All outputs are registered.
- With `start` accepted at cycle 0:
  - cycle 1: FETCH;
  - cycle 2: WAIT_DATA;
  - cycle 3: first ON cycle.
- Per-step period: `2 + (ON_TICKS+GAP_TICKS)*TICK_DIV` cycles.
- The tick prescaler is cleared in WAIT_DATA, so every ON/GAP duration is exact and free of phase jitter.
- `done` is asserted at cycle `1 + len*period`, with `busy`=1 in that cycle. `busy` is 0 from the following cycle.
- `len`=0: `done` at cycle 1, and `step_rd` is never asserted.

## Configuration
- `SIMON_SPEEDUP_EN` defined: when latched len ≥ `SPEEDUP_LEN`, the ON and GAP durations are `(ON_TICKS>>1)` and `(GAP_TICKS>>1)` ticks, each floored at 1. This applies for the whole playback.
- Undefined: durations are always `ON_TICKS`/`GAP_TICKS`, and `SPEEDUP_LEN` is unused.

## Structure
- Shared package `simon_pkg`:
  - state enum `play_state_t`;
  - colour codes GREEN=0, RED=1, BLUE=2, YELLOW=3;
  - typedef `color_t` (2 bits).
- Sub-module `simon_tick_div` is a prescaler emitting a one-cycle `tick` every `TICK_DIV` cycles. It has a synchronous `clr` input, driven in WAIT_DATA.
- The sequencer holds the FSM, the tick-down counter, the index and the colour register.

## Test plan
All scenarios use `TICK_DIV`=4, `ON_TICKS`=3, `GAP_TICKS`=2, `MAX_LEN`=31, so period = 22.
- RAM = {2,0}, `seq_len`=2, pulse `start` at cycle 0:
  - `step_rd` at cycles 1 and 23 (addr 0, 1);
  - `led`=4'b0100 for cycles 3–14 and 4'b0001 for cycles 25–36;
  - `tone_en` matches `led`≠0;
  - `done` at cycle 45 only; `busy` is 0 at cycle 46.
- `seq_len`=0 with `start` -> `done` at cycle 1; no `step_rd`, `led`, or `tone_en` activity.
- `seq_len`=3, `abort` at cycle 10 (during ON) -> cycle 11: state IDLE, `led`=0, `tone_en`=0, `busy`=0; no `done` pulse ever.
- Second `start` at cycle 5 during playback -> ignored; the timeline is identical to the first scenario.
- `rst_n` low at cycle 8 (during ON) -> outputs 0 immediately (asynchronous). After release, a new `start` restarts from index 0.
- With `SIMON_SPEEDUP_EN`, `SPEEDUP_LEN`=2, `seq_len`=2:
  - ON lasts 4 cycles (1 tick) and GAP lasts 4 cycles (1 tick), so period = 10;
  - `done` at cycle 21.
  - With `seq_len`=1, normal durations apply.
